// File: rtl/display_scheduler.sv
// Time-multiplexing controller for the shared seven-segment path: alternates the
// R and N code sets with a programmable dwell, blanking around each select change.
module display_scheduler #(
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       force_r,
    output logic       selector,
    output logic       blank,
    output logic       switch_pulse,
    output logic [2:0] state
);

    localparam int MAX_DB = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int MAX_V  = (MAX_DB > 2) ? MAX_DB : 2;
    localparam int CW     = $clog2(MAX_V);

    localparam logic [CW-1:0] DLAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SHOW_N     = 3'd1,
        BLANK_TO_R = 3'd2,
        SHOW_R     = 3'd3,
        BLANK_TO_N = 3'd4
    } state_t;

    // With no blanking the show states hand over to each other directly.
    localparam state_t TO_R = (BLANK_CYCLES == 0) ? SHOW_R : BLANK_TO_R;
    localparam state_t TO_N = (BLANK_CYCLES == 0) ? SHOW_N : BLANK_TO_N;

    state_t        st_q, st_d;
    logic [CW-1:0] cnt, cnt_d;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt;
        if (!enable) begin
            st_d  = IDLE;
            cnt_d = '0;
        end else begin
            case (st_q)
                IDLE: begin
                    st_d  = SHOW_N;
                    cnt_d = '0;
                end
                SHOW_N: begin
                    if (force_r || cnt == DLAST) begin
                        st_d  = TO_R;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                BLANK_TO_R: begin
                    if (cnt == BLAST) begin
                        st_d  = SHOW_R;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                SHOW_R: begin
                    // Holding cnt at 0 guarantees a full dwell once force_r drops.
                    if (force_r) begin
                        cnt_d = '0;
                    end else if (cnt == DLAST) begin
                        st_d  = TO_N;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                BLANK_TO_N: begin
                    if (force_r) begin
                        st_d  = BLANK_TO_R;
                        cnt_d = '0;
                    end else if (cnt == BLAST) begin
                        st_d  = SHOW_N;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= IDLE;
            cnt          <= '0;
            selector     <= 1'b0;
            blank        <= 1'b1;
            switch_pulse <= 1'b0;
        end else begin
            st_q         <= st_d;
            cnt          <= cnt_d;
            selector     <= (st_d == BLANK_TO_R) || (st_d == SHOW_R);
            blank        <= (st_d == IDLE) || (st_d == BLANK_TO_R) || (st_d == BLANK_TO_N);
            switch_pulse <= ((st_d == SHOW_N) || (st_d == SHOW_R)) && (st_d != st_q);
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: one instance with blanking, one without.
module tb_display_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       force_r = 1'b0;
    logic       en_b = 1'b0;
    logic       fr_b = 1'b0;
    logic       sel_a, blk_a, pls_a, sel_b, blk_b, pls_b;
    logic [2:0] st_a, st_b;

    display_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .force_r(force_r),
        .selector(sel_a), .blank(blk_a), .switch_pulse(pls_a), .state(st_a)
    );

    display_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .force_r(fr_b),
        .selector(sel_b), .blank(blk_b), .switch_pulse(pls_b), .state(st_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int sel;
        int blk;
        int pls;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ma_st = 0, ma_c = 0, mb_st = 0, mb_c = 0;
    int   oa_st, oa_sel, oa_blk, oa_pls, ob_st, ob_blk, ob_pls;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // Reference model, dwell fixed at 4.
    function automatic void mstep(input int bc, input int st, input int c, input logic en,
                                  input logic fr, output int nst, output int nc);
        nst = st;
        nc  = c;
        if (!en) begin
            nst = 0; nc = 0;
        end else begin
            case (st)
                0: begin nst = 1; nc = 0; end
                1: if (fr || c == 3) begin nst = (bc == 0) ? 3 : 2; nc = 0; end
                   else nc = c + 1;
                2: if (c == bc - 1) begin nst = 3; nc = 0; end
                   else nc = c + 1;
                3: if (fr) nc = 0;
                   else if (c == 3) begin nst = (bc == 0) ? 1 : 4; nc = 0; end
                   else nc = c + 1;
                4: if (fr) begin nst = 2; nc = 0; end
                   else if (c == bc - 1) begin nst = 1; nc = 0; end
                   else nc = c + 1;
                default: begin nst = 0; nc = 0; end
            endcase
        end
    endfunction

    function automatic exp_t mk(input int ps, input int ns);
        exp_t e;
        e.st  = ns;
        e.sel = (ns == 2 || ns == 3) ? 1 : 0;
        e.blk = (ns == 0 || ns == 2 || ns == 4) ? 1 : 0;
        e.pls = ((ns == 1 || ns == 3) && ns != ps) ? 1 : 0;
        return e;
    endfunction

    task automatic cycle();
        exp_t e;
        int   ns, nc;
        mstep(1, ma_st, ma_c, enable, force_r, ns, nc);
        qa.push_back(mk(ma_st, ns));
        ma_st = ns; ma_c = nc;
        mstep(0, mb_st, mb_c, en_b, fr_b, ns, nc);
        qb.push_back(mk(mb_st, ns));
        mb_st = ns; mb_c = nc;
        @(posedge clk);
        #1;
        if (qa.size() == 0) check("a.queue", 0, 1);
        else begin
            e = qa.pop_front();
            check("a.state", int'(st_a), e.st);
            check("a.selector", int'(sel_a), e.sel);
            check("a.blank", int'(blk_a), e.blk);
            check("a.pulse", int'(pls_a), e.pls);
        end
        if (qb.size() == 0) check("b.queue", 0, 1);
        else begin
            e = qb.pop_front();
            check("b.state", int'(st_b), e.st);
            check("b.selector", int'(sel_b), e.sel);
            check("b.blank", int'(blk_b), e.blk);
            check("b.pulse", int'(pls_b), e.pls);
        end
        oa_st = int'(st_a); oa_sel = int'(sel_a); oa_blk = int'(blk_a); oa_pls = int'(pls_a);
        ob_st = int'(st_b); ob_blk = int'(blk_b); ob_pls = int'(pls_b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".a.state"}, int'(st_a), 0);
        check({tag, ".a.selector"}, int'(sel_a), 0);
        check({tag, ".a.blank"}, int'(blk_a), 1);
        check({tag, ".a.pulse"}, int'(pls_a), 0);
        check({tag, ".b.state"}, int'(st_b), 0);
        check({tag, ".b.blank"}, int'(blk_b), 1);
    endtask

    int fr_tab[11] = '{1, 1, 1, 1, 2, 3, 3, 3, 3, 4, 1};

    initial begin
        int n, pulses, blanks, last_p;
        int sb[16];

        // Reset asserted with enable high, no clock edge yet
        enable = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("t1");
        #1 rst_n = 1'b1;

        // Free run
        for (int e = 0; e < 11; e++) begin
            cycle();
            check($sformatf("t2.edge%0d", e + 1), oa_st, fr_tab[e]);
        end
        check("t2.period_pulse", oa_pls, 1);

        // Force during second SHOW_N cycle, held 7 cycles
        for (int i = 0; i < 30 && !(oa_st == 1 && oa_pls == 1); i++) cycle();
        check("t3.sync", oa_st, 1);
        cycle();
        force_r = 1'b1;
        cycle();
        check("t3.blank_to_r", oa_st, 2);
        repeat (6) cycle();
        check("t3.hold_r", oa_st, 3);
        force_r = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && oa_st == 3; i++) begin
            n++;
            cycle();
        end
        check("t3.tail_dwell", n, 4);
        check("t3.after_tail", oa_st, 4);
        force_r = 1'b1;
        cycle();
        check("t3.btn_to_btr", oa_st, 2);
        force_r = 1'b0;

        // Disable in the third SHOW_R cycle
        for (int i = 0; i < 30 && !(oa_st == 3 && oa_pls == 1); i++) cycle();
        check("t4.sync", oa_st, 3);
        cycle();
        cycle();
        enable = 1'b0;
        cycle();
        check("t4.idle", oa_st, 0);
        check("t4.idle_sel", oa_sel, 0);
        check("t4.idle_blank", oa_blk, 1);
        cycle();
        enable = 1'b1;
        cycle();
        check("t4.restart_pulse", oa_pls, 1);
        n = 0;
        for (int i = 0; i < 20 && oa_st == 1; i++) begin
            n++;
            cycle();
        end
        check("t4.dwell", n, 4);
        check("t4.after_dwell", oa_st, 2);

        // No-blanking instance free run
        enable = 1'b0;
        en_b = 1'b1;
        pulses = 0; blanks = 0; last_p = -1;
        for (int e = 0; e < 16; e++) begin
            cycle();
            sb[e] = ob_st;
            if (ob_blk != 0) blanks++;
            if (ob_pls != 0) begin
                if (last_p >= 0) check($sformatf("t5.gap%0d", e + 1), e - last_p, 4);
                last_p = e;
                pulses++;
            end
        end
        check("t5.pulses", pulses, 4);
        check("t5.blanks", blanks, 0);
        check("t5.edge1", sb[0], 1);
        check("t5.edge5", sb[4], 3);
        check("t5.edge9", sb[8], 1);
        en_b = 1'b0;

        // Async reset in BLANK_TO_R
        enable = 1'b1;
        for (int i = 0; i < 30 && oa_st != 2; i++) cycle();
        check("t6.reach", oa_st, 2);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6");
        ma_st = 0; ma_c = 0; mb_st = 0; mb_c = 0;
        #2 rst_n = 1'b1;
        cycle();
        check("t6.resume", oa_st, 1);
        check("t6.resume_pulse", oa_pls, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
